conv1d_ctrl: RTL

Sequencer for the conv1d accelerator datapath. After a start command from the control registers it loads the kernel from the accelerator scratchpad into an internal coefficient file. It then computes a valid-mode 1-D convolution with a single multiply-accumulate unit, writes each result back to the scratchpad, and raises a completion pulse that drives the host interrupt. It sits between the conv1d control register block and the scratchpad memory port.

---
 rtl/conv1d_ctrl.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/conv1d_ctrl.sv
// rtl/conv1d_ctrl.sv - conv1d sequencer: kernel load, single-MAC valid-mode convolution, result write-back
// Optional ReLU on stored results when CONV1D_CTRL_RELU_EN is defined.
module conv1d_ctrl #(
   parameter int DataWidth = 32,
   parameter int AddrWidth = 10,
   parameter int MaxKernel = 16,
   localparam int KW = $clog2(MaxKernel) + 1
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 start_i,
   input  logic [AddrWidth-1:0] in_base_i,
   input  logic [AddrWidth-1:0] k_base_i,
   input  logic [AddrWidth-1:0] out_base_i,
   input  logic [AddrWidth-1:0] in_len_i,
   input  logic [KW-1:0]        k_len_i,
   output logic                 mem_req_o,
   output logic                 mem_we_o,
   output logic [AddrWidth-1:0] mem_addr_o,
   output logic [DataWidth-1:0] mem_wdata_o,
   input  logic                 mem_gnt_i,
   input  logic                 mem_rvalid_i,
   input  logic [DataWidth-1:0] mem_rdata_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 err_o
);
   localparam int IW = $clog2(MaxKernel);
   localparam logic [KW-1:0] KMax = KW'(MaxKernel);

   typedef enum logic [2:0] {IDLE, CHECK, LD_REQ, LD_WAIT, RD_REQ, RD_WAIT, STORE, DONE} state_e;

   state_e                state_q, state_d;
   logic [AddrWidth-1:0]  in_base_q, in_base_d, k_base_q, k_base_d, out_base_q, out_base_d;
   logic [AddrWidth-1:0]  n_len_q, n_len_d, n_q, n_d;
   logic [KW-1:0]         k_len_q, k_len_d, j_q, j_d;
   logic [DataWidth-1:0]  acc_q, acc_d;
   logic [DataWidth-1:0]  coef_q [MaxKernel];
   logic [DataWidth-1:0]  coef_d [MaxKernel];
   logic                  err_q, err_d;

   logic [IW-1:0]         j_idx;
   logic [AddrWidth-1:0]  j_ext, k_ext;
   logic [DataWidth-1:0]  prod, result;
   logic                  j_last;

   assign j_idx  = j_q[IW-1:0];
   assign j_ext  = {{(AddrWidth-KW){1'b0}}, j_q};
   assign k_ext  = {{(AddrWidth-KW){1'b0}}, k_len_q};
   assign j_last = (j_q == k_len_q - KW'(1));
   // Only the low DataWidth bits of the product are kept, so signedness does not matter here.
   assign prod   = mem_rdata_i * coef_q[j_idx];

`ifdef CONV1D_CTRL_RELU_EN
   assign result = acc_q[DataWidth-1] ? '0 : acc_q;
`else
   assign result = acc_q;
`endif

   assign busy_o = (state_q != IDLE);
   assign err_o  = err_q;

   always_comb begin
      state_d     = state_q;
      in_base_d   = in_base_q;
      k_base_d    = k_base_q;
      out_base_d  = out_base_q;
      n_len_d     = n_len_q;
      k_len_d     = k_len_q;
      n_d         = n_q;
      j_d         = j_q;
      acc_d       = acc_q;
      coef_d      = coef_q;
      err_d       = err_q;
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      done_o      = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               in_base_d  = in_base_i;
               k_base_d   = k_base_i;
               out_base_d = out_base_i;
               n_len_d    = in_len_i;
               k_len_d    = k_len_i;
               state_d    = CHECK;
            end
         end
         CHECK: begin
            if (k_len_q == '0 || k_len_q > KMax || k_ext > n_len_q) begin
               err_d   = 1'b1;
               state_d = DONE;
            end else begin
               err_d   = 1'b0;
               j_d     = '0;
               n_d     = '0;
               state_d = LD_REQ;
            end
         end
         LD_REQ: begin
            mem_req_o  = 1'b1;
            mem_addr_o = k_base_q + j_ext;
            if (mem_gnt_i) state_d = LD_WAIT;
         end
         LD_WAIT: begin
            if (mem_rvalid_i) begin
               coef_d[j_idx] = mem_rdata_i;
               if (j_last) begin
                  acc_d   = '0;
                  j_d     = '0;
                  state_d = RD_REQ;
               end else begin
                  j_d     = j_q + KW'(1);
                  state_d = LD_REQ;
               end
            end
         end
         RD_REQ: begin
            mem_req_o  = 1'b1;
            mem_addr_o = in_base_q + n_q + j_ext;
            if (mem_gnt_i) state_d = RD_WAIT;
         end
         RD_WAIT: begin
            if (mem_rvalid_i) begin
               acc_d = acc_q + prod;
               if (j_last) begin
                  state_d = STORE;
               end else begin
                  j_d     = j_q + KW'(1);
                  state_d = RD_REQ;
               end
            end
         end
         STORE: begin
            mem_req_o   = 1'b1;
            mem_we_o    = 1'b1;
            mem_addr_o  = out_base_q + n_q;
            mem_wdata_o = result;
            if (mem_gnt_i) begin
               if (n_q == n_len_q - k_ext) begin
                  state_d = DONE;
               end else begin
                  n_d     = n_q + AddrWidth'(1);
                  j_d     = '0;
                  acc_d   = '0;
                  state_d = RD_REQ;
               end
            end
         end
         DONE: begin
            done_o  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         in_base_q  <= '0;
         k_base_q   <= '0;
         out_base_q <= '0;
         n_len_q    <= '0;
         k_len_q    <= '0;
         n_q        <= '0;
         j_q        <= '0;
         acc_q      <= '0;
         err_q      <= 1'b0;
         for (int i = 0; i < MaxKernel; i++) coef_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         in_base_q  <= in_base_d;
         k_base_q   <= k_base_d;
         out_base_q <= out_base_d;
         n_len_q    <= n_len_d;
         k_len_q    <= k_len_d;
         n_q        <= n_d;
         j_q        <= j_d;
         acc_q      <= acc_d;
         err_q      <= err_d;
         coef_q     <= coef_d;
      end
   end
endmodule
